// File: rtl/arm_rom_pkg.sv
// Shared widths, types and constants for the byte-wide ARM program ROM.
package arm_rom_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 8;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] byte_t;

    // Value returned for any address outside the implemented range.
    localparam byte_t ROM_ERR_BYTE = 8'h00;

    // Built-in contents used when no init file is given: low address byte XOR A5.
    function automatic byte_t rom_pattern(input int unsigned idx);
        return byte_t'(idx) ^ 8'hA5;
    endfunction

endpackage

// File: rtl/rom_toggle_sync.sv
// Optional trigger synchronizer plus toggle edge detect.
// req is high for every clk edge at which the synchronized trigger differs
// from the last accepted level.
module rom_toggle_sync #(
    parameter int SYNC_STAGES = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic trigger,
    output logic trig_s,
    output logic req
);

    logic trig_q_reg;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign trig_s = trigger;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] sync_reg;
            for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_stage
                if (gi == 0) begin : g_first
                    // First stage samples the raw trigger; reset preloads it too.
                    always_ff @(posedge clk) begin
                        sync_reg[gi] <= trigger;
                    end
                end else begin : g_next
                    // Later stages shift; reset loads trigger so no phantom edge appears.
                    always_ff @(posedge clk) begin
                        if (rst) sync_reg[gi] <= trigger;
                        else     sync_reg[gi] <= sync_reg[gi-1];
                    end
                end
            end
            assign trig_s = sync_reg[SYNC_STAGES-1];
        end
    endgenerate

    // Remember the last accepted trigger level; reset absorbs any held level.
    always_ff @(posedge clk) begin
        if (rst)      trig_q_reg <= trig_s;
        else if (req) trig_q_reg <= trig_s;
    end

    assign req = trig_s ^ trig_q_reg;

endmodule

// File: rtl/arm_rom.sv
// Byte-wide read-only program memory with a toggle request/acknowledge handshake.
// Out-of-range addresses return ROM_ERR_BYTE and flag addr_err instead of aliasing.
module arm_rom
    import arm_rom_pkg::*;
#(
    parameter int    DEPTH       = 4096,
    parameter string INIT_FILE   = "",
    parameter int    SYNC_STAGES = 0
) (
    input  logic  clk,
    input  logic  rst,
    input  addr_t addr,
    input  logic  trigger,
    output byte_t data,
    output logic  ack,
    output logic  addr_err
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    byte_t mem [DEPTH];

    // Contents are fixed at elaboration: the built-in pattern.
    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            mem[i] = rom_pattern(i);
        end
    end

    logic trig_s;
    logic req;

    rom_toggle_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .rst     (rst),
        .trigger (trigger),
        .trig_s  (trig_s),
        .req     (req)
    );

    // Full-width unsigned compare so high addresses never wrap into the array.
    logic            in_range;
    logic [IDX_W-1:0] idx;
    assign in_range = (addr < addr_t'(DEPTH));
    assign idx      = addr[IDX_W-1:0];

    byte_t data_reg;
    logic  ack_reg;
    logic  addr_err_reg;

    // Accept one request per trigger edge: registered read, range flag, ack toggle.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_reg     <= ROM_ERR_BYTE;
            ack_reg      <= 1'b0;
            addr_err_reg <= 1'b0;
        end else if (req) begin
            ack_reg <= ~ack_reg;
            if (in_range) begin
                data_reg     <= mem[idx];
                addr_err_reg <= 1'b0;
            end else begin
                data_reg     <= ROM_ERR_BYTE;
                addr_err_reg <= 1'b1;
            end
        end
    end

    assign data     = data_reg;
    assign ack      = ack_reg;
    assign addr_err = addr_err_reg;

endmodule

// File: tb/tb_arm_rom.sv
// Directed bench for arm_rom: a clk-synchronous instance (DEPTH 4096) and a
// two-stage synchronized instance (DEPTH 256).
module tb_arm_rom;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr_a, addr_b;
    logic        trig_a, trig_b;
    logic [7:0]  data_a, data_b;
    logic        ack_a, ack_b;
    logic        err_a, err_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    arm_rom #(.DEPTH(4096), .INIT_FILE(""), .SYNC_STAGES(0)) u_a (
        .clk(clk), .rst(rst), .addr(addr_a), .trigger(trig_a),
        .data(data_a), .ack(ack_a), .addr_err(err_a)
    );

    arm_rom #(.DEPTH(256), .INIT_FILE(""), .SYNC_STAGES(2)) u_b (
        .clk(clk), .rst(rst), .addr(addr_b), .trigger(trig_b),
        .data(data_b), .ack(ack_b), .addr_err(err_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_a(input string tag, input logic [7:0] d, input logic k, input logic e);
        chk({tag, ".data"}, 32'(data_a), 32'(d));
        chk({tag, ".ack"}, 32'(ack_a), 32'(k));
        chk({tag, ".err"}, 32'(err_a), 32'(e));
        $display("[%0t] A %s addr=%h trig=%b data=%h ack=%b err=%b", $time, tag, addr_a, trig_a, data_a, ack_a, err_a);
    endtask

    task automatic chk_b(input string tag, input logic [7:0] d, input logic k, input logic e);
        chk({tag, ".data"}, 32'(data_b), 32'(d));
        chk({tag, ".ack"}, 32'(ack_b), 32'(k));
        chk({tag, ".err"}, 32'(err_b), 32'(e));
        $display("[%0t] B %s addr=%h trig=%b data=%h ack=%b err=%b", $time, tag, addr_b, trig_b, data_b, ack_b, err_b);
    endtask

    // Advance one rising edge and settle 1 ns past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; trig_a = 1'b0; trig_b = 1'b0; addr_a = '0; addr_b = '0;

        // 1. reset state, then idle with trigger held low
        tick(); tick();
        chk_a("reset", 8'h00, 1'b0, 1'b0);
        chk_b("reset", 8'h00, 1'b0, 1'b0);
        rst = 1'b0;
        repeat (5) tick();
        chk_a("idle", 8'h00, 1'b0, 1'b0);

        // 2. first read at address 0
        addr_a = 32'd0; trig_a = 1'b1;
        tick();
        chk_a("rd0", 8'hA5, 1'b1, 1'b0);
        tick();
        chk_a("rd0_hold", 8'hA5, 1'b1, 1'b0);

        // 3. all-ones address is out of range
        addr_a = 32'hFFFF_FFFF; trig_a = 1'b0;
        tick();
        chk_a("rd_ffff", 8'h00, 1'b0, 1'b1);

        // 4. consecutive reads up to and past the top of memory
        addr_a = 32'd1; trig_a = 1'b1;
        tick();
        chk_a("rd1", 8'hA4, 1'b1, 1'b0);
        addr_a = 32'd4095; trig_a = 1'b0;
        tick();
        chk_a("rd4095", 8'h5A, 1'b0, 1'b0);
        addr_a = 32'd4096; trig_a = 1'b1;
        tick();
        chk_a("rd4096", 8'h00, 1'b1, 1'b1);
        addr_a = 32'd300; trig_a = 1'b0;
        tick();
        chk_a("rd300", 8'h89, 1'b0, 1'b0);

        // 5. toggle and reset on the same edge: request dropped
        addr_a = 32'd7; trig_a = 1'b1; rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_a("rst_cancel", 8'h00, 1'b0, 1'b0);
        tick(); tick();
        chk_a("rst_noread", 8'h00, 1'b0, 1'b0);
        addr_a = 32'd2; trig_a = 1'b0;
        tick();
        chk_a("rd_after_rst", 8'hA7, 1'b1, 1'b0);

        // 6. synchronized instance, trigger changed away from the edge
        #2;
        addr_b = 32'd5; trig_b = 1'b1;
        tick();
        chk_b("sync_e1", 8'h00, 1'b0, 1'b0);
        tick();
        chk_b("sync_e2", 8'h00, 1'b0, 1'b0);
        tick();
        chk_b("sync_e3", 8'hA0, 1'b1, 1'b0);
        #3;
        addr_b = 32'd255; trig_b = 1'b0;
        tick(); tick();
        chk_b("sync_top_wait", 8'hA0, 1'b1, 1'b0);
        tick();
        chk_b("sync_top", 8'h5A, 1'b0, 1'b0);
        #3;
        addr_b = 32'd256; trig_b = 1'b1;
        repeat (3) tick();
        chk_b("sync_oor", 8'h00, 1'b1, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
